// File: rtl/dcf77_encoder.sv
// dcf77_encoder: latches a BCD time/date on start and sends it as one 60-second DCF77 pulse frame
module dcf77_encoder (
    input  logic        clk,
    input  logic        nReset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [43:0] timeAndDate_in,
    output logic        dcf_out,
    output logic        busy,
    output logic        frame_done,
    output logic [5:0]  second_idx
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t      state, state_n;
    logic [58:0] frame, frame_n, new_frame;
    logic [59:0] frame_pad;
    logic [6:0]  tick, tick_n, minute;
    logic [5:0]  sec_n, hour;
    logic [21:0] date;
    logic        done_n, dcf_n, unused_sec;
    assign minute     = timeAndDate_in[13:7];
    assign hour       = timeAndDate_in[19:14];
    assign date       = {timeAndDate_in[38:26], timeAndDate_in[41:39], timeAndDate_in[25:20]};
    assign new_frame  = {^date, date, ^hour, hour, ^minute, minute, 2'b10, timeAndDate_in[43:42], 17'd0};
    assign unused_sec = ^timeAndDate_in[6:0];
    assign busy       = state == SEND;
    assign frame_pad  = {1'b0, frame_n};
    always_comb begin
        state_n = state;
        frame_n = frame;
        tick_n  = tick;
        sec_n   = second_idx;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n = SEND;
                frame_n = new_frame;
                tick_n  = 7'd0;
                sec_n   = 6'd0;
            end
        end else if (clk_en) begin
            tick_n = (tick == 7'd99) ? 7'd0 : tick + 7'd1;
            if (tick == 7'd99) begin
                sec_n   = (second_idx == 6'd59) ? 6'd0 : second_idx + 6'd1;
                state_n = (second_idx == 6'd59) ? IDLE : SEND;
                done_n  = second_idx == 6'd59;
            end
        end
        // second 59 carries no pulse: it is the minute marker
        dcf_n = (state_n == SEND) && (sec_n < 6'd59) && (tick_n < (frame_pad[sec_n] ? 7'd20 : 7'd10));
    end
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            frame      <= '0;
            tick       <= '0;
            second_idx <= '0;
            frame_done <= 1'b0;
            dcf_out    <= 1'b0;
        end else begin
            state      <= state_n;
            frame      <= frame_n;
            tick       <= tick_n;
            second_idx <= sec_n;
            frame_done <= done_n;
            dcf_out    <= dcf_n;
        end
    end
endmodule

// File: tb/tb_dcf77_encoder.sv
// tb_dcf77_encoder: scoreboard bench comparing measured per-second pulse widths against a frame model
module tb_dcf77_encoder;
    logic        clk = 1'b0, nReset = 1'b0, clk_en = 1'b0, start = 1'b0;
    logic [43:0] td = '0;
    logic        dcf_out, busy, frame_done;
    logic [5:0]  second_idx;
    int checks = 0, failures = 0;
    logic [58:0] exp_q[$];
    int cnt[60], got_w[60];
    int tot = 0, done_cnt = 0;
    bit en_manual = 1'b0, en_rand = 1'b0;

    dcf77_encoder dut (
        .clk(clk), .nReset(nReset), .clk_en(clk_en), .start(start),
        .timeAndDate_in(td), .dcf_out(dcf_out), .busy(busy),
        .frame_done(frame_done), .second_idx(second_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [58:0] model(input logic [43:0] t);
        logic [58:0] f;
        int v[11];
        int w[11];
        int p, par, b;
        f = '0;
        f[17] = t[42];
        f[18] = t[43];
        f[20] = 1'b1;
        v = '{int'(t[10:7]), int'(t[13:11]), int'(t[17:14]), int'(t[19:18]), int'(t[23:20]), int'(t[25:24]),
              int'(t[41:39]), int'(t[29:26]), int'(t[30]), int'(t[34:31]), int'(t[38:35])};
        w = '{4, 3, 4, 2, 4, 2, 3, 4, 1, 4, 4};
        p = 21;
        par = 0;
        for (int k = 0; k < 11; k++) begin
            for (int j = 0; j < w[k]; j++) begin
                b = (v[k] >> j) & 1;
                f[p] = b[0];
                par = par ^ b;
                p++;
            end
            if (k == 1 || k == 3) begin
                f[p] = par[0];
                p++;
                par = 0;
            end
        end
        f[58] = par[0];
        return f;
    endfunction

    function automatic int width_of(input logic [58:0] f, input int s);
        if (s == 59) return 0;
        return f[s] ? 20 : 10;
    endfunction

    function automatic logic [43:0] mk(input int mn, input int hr, input int dy, input int mo,
                                       input int yr, input int wd, input int tz);
        return {2'(tz), 3'(wd), 4'(yr / 10), 4'(yr % 10), 1'(mo / 10), 4'(mo % 10),
                2'(dy / 10), 4'(dy % 10), 2'(hr / 10), 4'(hr % 10), 3'(mn / 10), 4'(mn % 10), 7'd0};
    endfunction

    function automatic logic [43:0] rnd_td();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[43:0];
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // clk_en source: every cycle or random, unless the stimulus takes manual control
    initial forever begin
        @(posedge clk);
        #1;
        if (!en_manual) clk_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor: measure pulse width per second in clk_en ticks, score at frame_done
    initial begin
        logic [58:0] e;
        foreach (cnt[i]) cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!nReset) begin
                foreach (cnt[i]) cnt[i] = 0;
                tot = 0;
            end else begin
                if (!busy) check("idle_dcf_out", int'(dcf_out), 0);
                if (frame_done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) check("unexpected_frame_done", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        for (int s = 0; s < 60; s++) check($sformatf("width_s%0d", s), cnt[s], width_of(e, s));
                        check("frame_ticks", tot, 6000);
                        got_w = cnt;
                    end
                end
                if (busy) begin
                    if (clk_en) begin
                        tot++;
                        if (dcf_out) cnt[second_idx]++;
                    end
                end else begin
                    foreach (cnt[i]) cnt[i] = 0;
                    tot = 0;
                end
            end
        end
    end

    task automatic send(input logic [43:0] t);
        check("idle_before_start", int'(busy), 0);
        td = t;
        exp_q.push_back(model(t));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("sec_after_start", int'(second_idx), 0);
        check("dcf_at_entry", int'(dcf_out), 1);
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (frame_done) ok = 1'b1;
        end
        if (!ok) check("frame_done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sec(input int s, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (second_idx == 6'(s)) ok = 1'b1;
        end
        if (!ok) check($sformatf("wait_sec%0d_timeout", s), 0, 1);
    endtask

    initial begin
        int min_bits[7];
        int hr_bits[6];
        int p, base;
        logic [43:0] t;
        logic        d0;
        logic [5:0]  s0;
        min_bits = '{1, 0, 0, 1, 1, 0, 1};
        hr_bits  = '{1, 1, 0, 0, 0, 1};
        repeat (3) @(posedge clk);
        #1;
        check("rst_dcf_out", int'(dcf_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_second_idx", int'(second_idx), 0);
        nReset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 23:59, 31.07.19, weekday 2, clk_en every cycle
        send(mk(59, 23, 31, 7, 19, 2, 0));
        wait_done(7000);
        for (int i = 0; i < 7; i++) check($sformatf("min_bit%0d", 21 + i), got_w[21 + i], min_bits[i] ? 20 : 10);
        check("min_parity", got_w[28], 10);
        for (int i = 0; i < 6; i++) check($sformatf("hour_bit%0d", 29 + i), got_w[29 + i], hr_bits[i] ? 20 : 10);
        check("hour_parity", got_w[35], 20);
        check("bit20", got_w[20], 20);
        check("sec0_width", got_w[0], 10);
        check("sec20_width", got_w[20], 20);
        check("sec59_width", got_w[59], 0);

        // random fields, tz=10, random clk_en
        en_rand = 1'b1;
        t = rnd_td();
        t[43:42] = 2'b10;
        send(t);
        wait_done(20000);
        check("tz_bit17", got_w[17], 10);
        check("tz_bit18", got_w[18], 20);
        p = 0;
        for (int i = 36; i < 58; i++) p = p ^ int'(got_w[i] == 20);
        check("date_parity", int'(got_w[58] == 20), p);

        // reset mid-frame at second 30, tick 5
        en_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(mk($urandom_range(0, 59), $urandom_range(0, 23), $urandom_range(1, 31), $urandom_range(1, 12),
                $urandom_range(0, 99), $urandom_range(1, 7), $urandom_range(0, 3)));
        wait_sec(30, 4000);
        repeat (5) @(posedge clk);
        #2;
        check("pre_reset_dcf", int'(dcf_out), 1);
        nReset = 1'b0;
        #1;
        check("async_rst_dcf", int'(dcf_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_sec", int'(second_idx), 0);
        check("async_rst_done", int'(frame_done), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        nReset = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_dcf", int'(dcf_out), 0);

        // start and input changes during SEND must not disturb the frame
        base = done_cnt;
        send(rnd_td());
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(1, 100)) @(posedge clk);
            #1;
            td = rnd_td();
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(7000);
        repeat (20) @(posedge clk);
        #1;
        check("single_frame_done", done_cnt - base, 1);
        check("idle_after_frame", int'(busy), 0);

        // clk_en low for 50 cycles in the middle of the second-10 pulse
        send(rnd_td());
        wait_sec(10, 2000);
        repeat (2) @(posedge clk);
        #1;
        en_manual = 1'b1;
        clk_en = 1'b0;
        d0 = dcf_out;
        s0 = second_idx;
        check("freeze_mid_pulse", int'(d0), 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("freeze_dcf_c%0d", i), int'(dcf_out), int'(d0));
            check($sformatf("freeze_sec_c%0d", i), int'(second_idx), int'(s0));
        end
        en_manual = 1'b0;
        wait_done(7000);

        // fully random inputs including illegal BCD digits, random clk_en
        en_rand = 1'b1;
        send(rnd_td());
        wait_done(20000);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcf77_encoder.md
DCF77_ENCODER -- requirements
Module: dcf77_encoder

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port nReset, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port clk_en, input, 1, 10 ms tick, one clk wide; all timing advances only on clk edges with clk_en=1.
REQ-004 SHALL have port start, input, 1, frame request, sampled on any clk edge.
REQ-005 SHALL have port timeAndDate_in, input, 44, BCD time/date in the system's 44-bit time-and-date layout.
- Field layout: sec [6:0]; min lo [10:7], hi [13:11]; hour lo [17:14], hi [19:18]; day lo [23:20], hi [25:24]; month lo [29:26], hi [30]; year lo [34:31], hi [38:35]; weekday [41:39]; timezone [43:42].
REQ-006 SHALL have port dcf_out, output, 1, encoded DCF77 pulse stream; 1 = carrier reduction.
REQ-007 SHALL have port busy, output, 1, frame transmission in progress.
REQ-008 SHALL have port frame_done, output, 1, one-clk pulse at end of frame.
REQ-009 SHALL have port second_idx, output, 6, index 0..59 of the second being sent.

Function
REQ-010 SHALL be a two-state FSM: IDLE and SEND.
REQ-011 SHALL, in IDLE with start=1, latch a 59-bit frame on that edge, then enter SEND with second_idx=0 and tick counter=0; busy=1 from the next cycle.
REQ-012 SHALL build the frame as follows:
- bits 0-16 = 0;
- bit 17 = timeAndDate_in[42], bit 18 = timeAndDate_in[43];
- bit 19 = 0, bit 20 = 1;
- bits 21-27 = minute (lo[3:0], hi[2:0]), LSB first;
- bit 28 = even parity over bits 21-27;
- bits 29-34 = hour (lo, hi[1:0]), bit 35 = even parity over bits 29-34;
- bits 36-41 = day, bits 42-44 = weekday, bits 45-49 = month, bits 50-57 = year;
- bit 58 = even parity over bits 36-57.
REQ-013 SHALL ignore the seconds field and SHALL encode BCD fields unchecked, including illegal digits.
REQ-014 SHALL use a 7-bit tick counter 0..99 that increments on clk_en in SEND; at 99 it wraps to 0 and second_idx increments.
REQ-015 SHALL drive dcf_out as a register: 1 when in SEND, second_idx<59 and tick<10 (frame bit 0) or tick<20 (frame bit 1); otherwise 0.
REQ-016 SHALL assert dcf_out=1 on the cycle SEND is entered, i.e. second 0, tick 0.
REQ-017 SHALL hold dcf_out=0 for all 100 ticks of second 59 (minute marker).
REQ-018 SHALL, on the clk_en that wraps tick 99 of second 59, pulse frame_done for one clk, return to IDLE, and clear busy and second_idx on that edge.
REQ-019 SHALL ignore start while in SEND; the latched frame is not altered by timeAndDate_in changes during SEND.
REQ-020 SHALL accept start on the same cycle as frame_done only from the following cycle, i.e. once IDLE is reached.
REQ-021 SHALL freeze all state while clk_en=0.

Reset
REQ-022 SHALL, on nReset=0 at any time including mid-frame, immediately force IDLE, dcf_out=0, busy=0, frame_done=0, second_idx=0, tick=0 and frame register=0.
REQ-023 SHALL, after nReset deassertion, wait for a new start before sending.

Verification
REQ-024 SHALL check: input 23:59, day 31, month 07, year 19, weekday 2, tz 0; start -> bits 21-27=1001101, bit 28=0, bits 29-34=110001, bit 35=1, bit 20=1.
REQ-025 SHALL check, with the same frame and clk_en every cycle: second 0 pulse 10 clk wide; second 20 pulse 20 clk wide; second 59 no pulse; frame_done after 6000 clk_en ticks.
REQ-026 SHALL check: tz=2'b10 -> bit 17=0, bit 18=1; date parity bit 58 equals XOR of bits 36-57.
REQ-027 SHALL check: nReset low at second 30, tick 5 -> dcf_out=0 and busy=0 immediately; no output until the next start.
REQ-028 SHALL check: start and timeAndDate_in changes during SEND -> frame unchanged, single frame_done.
REQ-029 SHALL check: clk_en held low for 50 cycles mid-pulse -> dcf_out, tick and second_idx unchanged.
